// File: rtl/axi_pkg.sv
// Shared types and helpers for the AXI write-channel responder.
package axi_pkg;

    localparam int IDX_W = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // WRAP keeps the bits above len fixed, so the index cycles inside an aligned block.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [3:0]       len,
                                                  input burst_t           burst);
        logic [IDX_W-1:0] mask;
        mask = {{(IDX_W-4){1'b0}}, len};
        case (burst)
            BURST_INCR: next_idx = idx + 1'b1;
            BURST_WRAP: next_idx = (idx & ~mask) | ((idx + 1'b1) & mask);
            default:    next_idx = idx;
        endcase
    endfunction

endpackage

// File: rtl/axi_mem_responder.sv
// AXI write responder: takes AW/W/B bursts into a small byte-strobed word memory
// and exposes a registered debug read port plus a committed-beat counter.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic [3:0]                   awid_i,
    input  logic [3:0]                   awlen_i,
    input  logic [2:0]                   awsize_i,
    input  logic [1:0]                   awburst_i,
    input  logic [ADDR_WIDTH-1:0]        awaddr_i,
    input  logic                         awvalid_i,
    output logic                         awready_o,
    input  logic [3:0]                   wid_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      wstrb_i,
    input  logic                         wlast_i,
    input  logic                         wvalid_i,
    output logic                         wready_o,
    output logic [3:0]                   bid_o,
    output logic [1:0]                   bresp_o,
    output logic                         bvalid_o,
    input  logic                         bready_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr_i,
    output logic [DATA_WIDTH-1:0]        dbg_data_o,
    output logic [15:0]                  wr_beats_o
);

    localparam int                 MEM_AW  = $clog2(MEM_DEPTH);
    localparam int                 LANES   = DATA_WIDTH / 8;
    localparam logic [IDX_W:0]     DEPTH_L = (IDX_W+1)'(MEM_DEPTH);

    wr_state_t        r_state;
    logic [3:0]       r_id;
    logic [3:0]       r_len;
    logic [3:0]       r_beat;
    burst_t           r_burst;
    logic [IDX_W-1:0] r_idx;
    logic             r_hi;
    logic             r_aw_err;
    logic             r_err;
    logic [15:0]      r_beats;

    logic w_aw_err;
    logic w_last_beat;
    logic w_in_range;
    logic w_we;

    assign w_aw_err = (awsize_i != 3'd2) || (awburst_i == 2'b11) || (awaddr_i[1:0] != 2'b00) ||
                      ((awburst_i == 2'b10) && !(awlen_i inside {4'd1, 4'd3, 4'd7, 4'd15}));

    // r_hi covers address bits above the tracked index, and INCR overflow of the index.
    assign w_last_beat = (r_beat == r_len);
    assign w_in_range  = !r_hi && !r_aw_err && ({1'b0, r_idx} < DEPTH_L);
    assign w_we        = (r_state == W_DATA) && wvalid_i && w_in_range;

    assign awready_o  = (r_state == W_IDLE);
    assign wready_o   = (r_state == W_DATA);
    assign bvalid_o   = (r_state == W_RESP);
    assign bid_o      = r_id;
    assign bresp_o    = r_err ? RESP_SLVERR : RESP_OKAY;
    assign wr_beats_o = r_beats;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state  <= W_IDLE;
            r_id     <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_burst  <= BURST_FIXED;
            r_idx    <= '0;
            r_hi     <= 1'b0;
            r_aw_err <= 1'b0;
            r_err    <= 1'b0;
            r_beats  <= '0;
        end else begin
            case (r_state)
                W_IDLE: begin
                    if (awvalid_i) begin
                        r_id     <= awid_i;
                        r_len    <= awlen_i;
                        r_burst  <= burst_t'(awburst_i);
                        r_idx    <= awaddr_i[IDX_W+1:2];
                        r_hi     <= |awaddr_i[ADDR_WIDTH-1:IDX_W+2];
                        r_aw_err <= w_aw_err;
                        r_beat   <= '0;
                        r_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid_i) begin
                        r_err <= r_err | !w_in_range | (wid_i != r_id) | (wlast_i != w_last_beat);
                        if (w_we) begin
                            r_beats <= r_beats + 16'd1;
                        end
                        r_idx <= next_idx(r_idx, r_len, r_burst);
                        if ((r_burst == BURST_INCR) && (&r_idx)) begin
                            r_hi <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_state <= W_RESP;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        r_state <= W_IDLE;
                        r_err   <= 1'b0;
                        r_beat  <= '0;
                    end
                end
                default: r_state <= W_IDLE;
            endcase
        end
    end

    // One storage array per byte lane keeps strobed writes independent.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] r_mem [MEM_DEPTH];
        logic [7:0] r_dbg;

        always_ff @(posedge clk or negedge areset) begin
            if (!areset) begin
                for (int w = 0; w < MEM_DEPTH; w++) begin
                    r_mem[w] <= '0;
                end
                r_dbg <= '0;
            end else begin
                if (w_we && wstrb_i[gi]) begin
                    r_mem[r_idx[MEM_AW-1:0]] <= wdata_i[gi*8 +: 8];
                end
                r_dbg <= r_mem[dbg_addr_i];
            end
        end

        assign dbg_data_o[gi*8 +: 8] = r_dbg;
    end

endmodule
